// File: rtl/line_render_scheduler.sv
// Per-line render sequencer: latches the next line index, flips the line-buffer bank and
// issues layer1/layer2/sprite start pulses in parallel or one at a time, tracking overruns.
module line_render_scheduler #(
  parameter logic [8:0] LAST_LINE = 9'd479
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] display_line_idx,
  input  logic       display_start_of_line,
  input  logic       display_start_of_screen,
  input  logic [2:0] unit_en,
  input  logic       serial_mode,
  input  logic [2:0] unit_done,
  input  logic       status_clear,
  output logic [8:0] unit_line_idx,
  output logic [2:0] unit_start,
  output logic       render_bank,
  output logic       busy,
  output logic       overrun_sticky,
  output logic [7:0] overrun_count
);

  typedef enum logic [2:0] {StIdle, StRun, StL1, StL2, StSpr} state_e;

  state_e     state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] start_q, start_d;
  logic [8:0] line_q, line_d;
  logic       bank_q, bank_d;
  logic       sticky_q, sticky_d;
  logic [7:0] count_q, count_d;
  logic       overrun;
  logic [2:0] cur_unit;

  function automatic logic [2:0] lowest_set(input logic [2:0] m);
    return m & (~m + 3'd1);
  endfunction

  function automatic state_e serial_state(input logic [2:0] onehot);
    case (onehot)
      3'b001:  return StL1;
      3'b010:  return StL2;
      3'b100:  return StSpr;
      default: return StIdle;
    endcase
  endfunction

  always_comb begin
    cur_unit = 3'b000;
    unique case (state_q)
      StL1:    cur_unit = 3'b001;
      StL2:    cur_unit = 3'b010;
      StSpr:   cur_unit = 3'b100;
      default: cur_unit = 3'b000;
    endcase
  end

  // A done landing in the SOL cycle retires its unit before the overrun test.
  assign overrun = display_start_of_line & (|(pending_q & ~unit_done));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q & ~unit_done;
    start_d   = 3'b000;
    line_d    = line_q;
    bank_d    = bank_q;
    sticky_d  = sticky_q;
    count_d   = count_q;

    if (display_start_of_line) begin
      line_d    = (display_line_idx == LAST_LINE) ? 9'd0 : display_line_idx + 9'd1;
      bank_d    = display_start_of_screen ? 1'b0 : ~bank_q;
      pending_d = unit_en;
      if (serial_mode) begin
        start_d = lowest_set(unit_en);
        state_d = serial_state(start_d);
      end else begin
        start_d = unit_en;
        state_d = (unit_en != 3'b000) ? StRun : StIdle;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (pending_d == 3'b000) state_d = StIdle;
        end
        StL1, StL2, StSpr: begin
          // Hand VRAM to the next still-pending unit once the current one finishes.
          if (|(unit_done & cur_unit & pending_q)) begin
            start_d = lowest_set(pending_d);
            state_d = serial_state(start_d);
          end
        end
        default: ;
      endcase
    end

    if (overrun) begin
      sticky_d = 1'b1;
      if (status_clear)          count_d = 8'd1;
      else if (count_q != 8'hff) count_d = count_q + 8'd1;
    end else if (status_clear) begin
      sticky_d = 1'b0;
      count_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 3'b000;
      start_q   <= 3'b000;
      line_q    <= 9'd0;
      bank_q    <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      line_q    <= line_d;
      bank_q    <= bank_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  assign unit_line_idx  = line_q;
  assign unit_start     = start_q;
  assign render_bank    = bank_q;
  assign busy           = |pending_q;
  assign overrun_sticky = sticky_q;
  assign overrun_count  = count_q;

endmodule
